aes_key_schedule: RTL

Iterative AES key-expansion engine for 128-, 192- and 256-bit keys, selected by parameter. From one cipher key it produces one 32-bit schedule word per clock and presents each completed 128-bit round key on a registered output with a one-cycle valid strobe. It replaces the single-step combinational round-key function and sits between key load and the round datapath, sharing one four-S-box SubWord instance.

---
 rtl/aes_key_schedule_if.sv | 27 ++
 rtl/aes_key_schedule.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_if.sv
// Key-schedule port bundle: start/key toward the engine, round-key stream back.
// AES_KS_STORE_EN adds the round-key store read port (rd_round/rd_key).
interface aes_key_schedule_if #(
    parameter int unsigned KEY_BITS = 128
);
    logic                start;
    logic [KEY_BITS-1:0] key_in;
    logic                busy;
    logic                rk_valid;
    logic [3:0]          rk_round;
    logic [127:0]        rk_out;
    logic                done;
`ifdef AES_KS_STORE_EN
    logic [3:0]          rd_round;
    logic [127:0]        rd_key;

    modport master (output start, key_in, rd_round,
                    input  busy, rk_valid, rk_round, rk_out, done, rd_key);
    modport slave  (input  start, key_in, rd_round,
                    output busy, rk_valid, rk_round, rk_out, done, rd_key);
`else
    modport master (output start, key_in,
                    input  busy, rk_valid, rk_round, rk_out, done);
    modport slave  (input  start, key_in,
                    output busy, rk_valid, rk_round, rk_out, done);
`endif
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock.
// Optional round-key store with read port when AES_KS_STORE_EN is defined.
module aes_key_schedule #(
    parameter int unsigned KEY_BITS = 128
) (
    input logic              clk,
    input logic              rst_n,
    aes_key_schedule_if.slave ks
);
    localparam int unsigned NK   = KEY_BITS / 32;
    localparam int unsigned NR   = NK + 6;
    localparam int unsigned LAST = 4 * (NR + 1) - 1;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0), then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    typedef enum logic [0:0] {StIdle, StGen} state_e;

    state_e       state_q;
    logic [31:0]  win_q [NK];
    logic [5:0]   idx_q;
    logic [2:0]   kc_q;
    logic [7:0]   rcon_q;
    logic [95:0]  asm_q;
    logic         busy_q;
    logic         rk_valid_q;
    logic [3:0]   rk_round_q;
    logic [127:0] rk_out_q;
    logic         done_q;

    logic [31:0]  prev;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  t;
    logic [31:0]  w_new;
    logic         accept;
    logic         rk_wr;

    assign accept = (state_q == StIdle) && ks.start;
    assign rk_wr  = (state_q == StGen) && (idx_q[1:0] == 2'd3);

    // Single shared SubWord: RotWord is applied in front of it only on i mod Nk == 0.
    always_comb begin
        prev    = win_q[NK-1];
        sub_in  = (kc_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out = '0;
        for (int b = 0; b < 4; b++) sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
        if (kc_q == 3'd0)                  t = sub_out ^ {rcon_q, 24'h0};
        else if (NK == 8 && kc_q == 3'd4)  t = sub_out;
        else                               t = prev;
        w_new = (idx_q < 6'(NK)) ? win_q[0] : (win_q[0] ^ t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            for (int j = 0; j < NK; j++) win_q[j] <= '0;
            idx_q      <= '0;
            kc_q       <= '0;
            rcon_q     <= 8'h01;
            asm_q      <= '0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_round_q <= '0;
            rk_out_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ks.start) begin
                        for (int j = 0; j < NK; j++) win_q[j] <= ks.key_in[KEY_BITS-1-32*j -: 32];
                        idx_q   <= '0;
                        kc_q    <= '0;
                        rcon_q  <= 8'h01;
                        busy_q  <= 1'b1;
                        state_q <= StGen;
                    end
                end
                StGen: begin
                    // Key words rotate through the window, so it wraps back into order at i = Nk.
                    for (int j = 0; j < NK - 1; j++) win_q[j] <= win_q[j+1];
                    win_q[NK-1] <= w_new;
                    asm_q       <= {asm_q[63:0], w_new};
                    if (idx_q >= 6'(NK) && kc_q == 3'd0) rcon_q <= xtime(rcon_q);
                    kc_q  <= (kc_q == 3'(NK - 1)) ? 3'd0 : kc_q + 3'd1;
                    idx_q <= idx_q + 6'd1;
                    if (idx_q[1:0] == 2'd3) begin
                        rk_out_q   <= {asm_q, w_new};
                        rk_round_q <= idx_q[5:2];
                        rk_valid_q <= 1'b1;
                    end
                    if (idx_q == 6'(LAST)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ks.busy     = busy_q;
    assign ks.rk_valid = rk_valid_q;
    assign ks.rk_round = rk_round_q;
    assign ks.rk_out   = rk_out_q;
    assign ks.done     = done_q;

`ifdef AES_KS_STORE_EN
    logic [127:0] mem_q [NR+1];
    logic [NR:0]  vld_q;
    logic [127:0] rd_key_q;
    logic [127:0] rd_next;

    always_ff @(posedge clk) begin
        if (rk_wr) mem_q[idx_q[5:2]] <= {asm_q, w_new};
    end

    always_comb begin
        rd_next = '0;
        for (int r = 0; r <= NR; r++) begin
            if (ks.rd_round == 4'(r) && vld_q[r]) rd_next = mem_q[r];
        end
    end

    // A read coinciding with start sees the store as already cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            rd_key_q <= '0;
        end else begin
            if (accept)     vld_q <= '0;
            else if (rk_wr) vld_q[idx_q[5:2]] <= 1'b1;
            rd_key_q <= accept ? '0 : rd_next;
        end
    end

    assign ks.rd_key = rd_key_q;
`endif
endmodule
